// File: rtl/uart_rx_mon_if.sv
// Bundle of the serial input, pop/clear controls and monitor outputs for uart_rx_mon.
// The slave modport is the receiver's view; the master modport is the consumer/driver view.
interface uart_rx_mon_if;
    logic        RxD;
    logic        rd;
    logic        clear;
    logic [7:0]  dout;
    logic        valid;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic [31:0] history;
    logic [15:0] byte_cnt;

    modport slave (
        input  RxD, rd, clear,
        output dout, valid, frame_err, parity_err, overrun, history, byte_cnt
    );

    modport master (
        output RxD, rd, clear,
        input  dout, valid, frame_err, parity_err, overrun, history, byte_cnt
    );
endinterface

// File: rtl/uart_rx_mon.sv
// Receive-side UART monitor: 8N1 decoder with a last-byte holding register, sticky error flags and a 4-byte history.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_err flag.
module uart_rx_mon #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200
) (
    input  logic         CLK,
    input  logic         RESET,
    uart_rx_mon_if.slave bus
);
    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PAR,
`endif
        STOP,
        WAIT
    } state_t;

    state_t        state, state_n;
    logic          sync1, rxs;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          div_restart;
    logic [3:0]    tcnt, tcnt_n;
    logic [2:0]    bcnt, bcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          store, set_frame, set_parity;

    logic [7:0]    dout_q;
    logic          valid_q;
    logic          frame_q;
    logic          overrun_q;
    logic [31:0]   history_q;
    logic [15:0]   cnt_q;

`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_n;
    logic          parity_q;
`endif

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            div_cnt <= '0;
            state   <= IDLE;
            tcnt    <= 4'd0;
            bcnt    <= 3'd0;
            shreg   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            sync1   <= bus.RxD;
            rxs     <= sync1;
            if (div_restart || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
            state   <= state_n;
            tcnt    <= tcnt_n;
            bcnt    <= bcnt_n;
            shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_n;
`endif
        end
    end

    // Every bit-period state samples on the 16th tick; START samples on the 8th to land mid start bit.
    always_comb begin
        state_n     = state;
        tcnt_n      = tcnt;
        bcnt_n      = bcnt;
        shreg_n     = shreg;
        div_restart = 1'b0;
        store       = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n       = par_bit;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n     = START;
                    tcnt_n      = 4'd0;
                    div_restart = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt == 4'd7) begin
                        tcnt_n = 4'd0;
                        bcnt_n = 3'd0;
                        state_n = rxs ? IDLE : DATA;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == 4'd15) begin
                        tcnt_n  = 4'd0;
                        shreg_n = {rxs, shreg[7:1]};
                        bcnt_n  = bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PAR;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PAR: begin
                if (tick) begin
                    if (tcnt == 4'd15) begin
                        tcnt_n  = 4'd0;
                        par_n   = rxs;
                        state_n = STOP;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tcnt == 4'd15) begin
                        tcnt_n = 4'd0;
                        if (!rxs) begin
                            set_frame = 1'b1;
                            state_n   = WAIT;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bit != ^shreg) begin
                            set_parity = 1'b1;
                            state_n    = IDLE;
`endif
                        end else begin
                            store   = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            WAIT: begin
                if (rxs)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A store outranks a same-cycle pop; clear outranks everything except valid/dout.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            dout_q    <= 8'd0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
            history_q <= 32'd0;
            cnt_q     <= 16'd0;
        end else begin
            if (store)
                dout_q <= shreg;

            if (store)
                valid_q <= 1'b1;
            else if (bus.rd)
                valid_q <= 1'b0;

            if (bus.clear)
                frame_q <= 1'b0;
            else if (set_frame)
                frame_q <= 1'b1;

            if (bus.clear)
                overrun_q <= 1'b0;
            else if (store && valid_q && !bus.rd)
                overrun_q <= 1'b1;

            if (bus.clear)
                history_q <= store ? {24'd0, shreg} : 32'd0;
            else if (store)
                history_q <= {history_q[23:0], shreg};

            if (bus.clear)
                cnt_q <= store ? 16'd1 : 16'd0;
            else if (store)
                cnt_q <= cnt_q + 16'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!RESET)
            parity_q <= 1'b0;
        else if (bus.clear)
            parity_q <= 1'b0;
        else if (set_parity)
            parity_q <= 1'b1;
    end

    assign bus.parity_err = parity_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_q;
    assign bus.overrun   = overrun_q;
    assign bus.history   = history_q;
    assign bus.byte_cnt  = cnt_q;

endmodule
